// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: DrawX/DrawY counters with registered blank, sync and strobe decodes.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by two clocks to match a ROM-plus-register renderer.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_timing_too_large
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // 11-bit bounds so an end-of-range equal to 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEGIN   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [10:0] x_wide;
  logic [10:0] y_wide;
  logic        hs_now;
  logic        vs_now;

  always_comb begin
    x_next = DrawX + 10'd1;
    y_next = DrawY;
    if (DrawX == H_LAST) begin
      x_next = '0;
      y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
  end

  assign x_wide = {1'b0, x_next};
  assign y_wide = {1'b0, y_next};

  // Flags decode the next-state counters so they land on the same edge as DrawX/DrawY.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs_now      <= 1'b1;
      vs_now      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      blank       <= (x_wide < H_ACT_END) && (y_wide < V_ACT_END);
      hs_now      <= !((x_wide >= HS_BEGIN) && (x_wide < HS_END));
      vs_now      <= !((y_wide >= VS_BEGIN) && (y_wide < VS_END));
      line_start  <= (x_next == '0);
      frame_start <= (x_next == '0) && (y_next == '0);
    end
  end

  assign sync = 1'b0;

`ifdef VGA_SYNC_DELAY_EN
  logic [1:0] hs_pipe;
  logic [1:0] vs_pipe;

  // Stages reset to the inactive sync level so no spurious pulse follows reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_pipe <= 2'b11;
      vs_pipe <= 2'b11;
    end else begin
      hs_pipe <= {hs_pipe[0], hs_now};
      vs_pipe <= {vs_pipe[0], vs_now};
    end
  end

  assign hs = hs_pipe[1];
  assign vs = vs_pipe[1];
`else
  assign hs = hs_now;
  assign vs = vs_now;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the display pipeline: DrawX/DrawY pixel coordinates, active-video flag, and hsync/vsync.
- Drives every pixel renderer in the design (sprite, background and palette blocks), which consume DrawX, DrawY and blank on vga_clk.
- Default timing is 640x480 at 60 Hz from a 25 MHz vga_clk.
- Also emits line_start and frame_start strobes so renderers can latch per-line and per-frame state.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanking
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- sync  out  1  composite sync for the DAC; tied 0
- line_start  out  1  one-clock pulse when DrawX==0
- frame_start  out  1  one-clock pulse when DrawX==0 and DrawY==0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters (default 800); V_TOTAL = sum of the four V_* parameters (default 525).
- Elaboration checks: H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024, enforced with a static assertion.
- Counters: DrawX and DrawY are the counter registers themselves.
  - DrawX increments every clock.
  - At DrawX==H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawX==H_TOTAL-1 and DrawY==V_TOTAL-1, both counters wrap to 0 on the same edge.
- Decodes: hs, vs, blank, line_start and frame_start are registered decodes of the next-state counter values. They are therefore cycle-aligned with DrawX/DrawY, with 0 cycles of skew between coordinate and flags.
  - hs = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vs = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491). vs is line-granular: it changes on the edge where DrawX becomes 0.
  - blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Reset, while asserted:
  - DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0, sync=0.
  - blank is forced 0 during reset regardless of the counters.
- Reset release: on the first edge with reset low, DrawX=1, DrawY=0, blank=1. The frame_start of the post-reset frame is therefore skipped; the next frame_start occurs at the following wrap.
- Reset asserted mid-frame: on the next edge, all outputs and counters take their reset values. No partial-line completion.
- Visible-region boundaries:
  - DrawX=639→640: blank falls on the edge DrawX becomes 640.
  - DrawY=479→480: blank stays 0 for all of lines 480..524.
- Downstream renderers own their own pixel-pipeline latency. This block guarantees only zero skew between DrawX/DrawY and the flags, unless the optional feature below is enabled.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- When defined:
  - hs and vs pass through a 2-stage shift register.
  - They lag DrawX/DrawY and blank by exactly 2 vga_clk cycles, matching a renderer with ROM read plus output register.
  - Delay stages reset to 1.
  - blank, line_start and frame_start are unaffected.
- When undefined: hs and vs are cycle-aligned with DrawX, as specified above.

Test Plan:
- Reset held 5 clocks, then released: DrawX=0, DrawY=0, hs=vs=1, blank=0 during reset; first cycle after release shows DrawX=1, blank=1.
- Run one full line: hs low for exactly 96 consecutive clocks starting at DrawX=656; blank=1 for DrawX 0..639 on line 0; DrawX wraps 799→0 and DrawY 0→1 on the same edge.
- Run one full frame (420000 clocks): vs low exactly for DrawY 490 and 491 (1600 clocks); frame_start pulses once, at DrawX=0, DrawY=0; 525 line_start pulses.
- Assert reset at DrawX=300, DrawY=200 for 1 clock: next edge shows DrawX=0, DrawY=0, blank=0, hs=vs=1; counting resumes.
- Check the wrap at DrawX=799, DrawY=524: both counters become 0, frame_start=1, blank=1, vs=1.
- With VGA_SYNC_DELAY_EN defined: hs falls at DrawX=658 and rises at DrawX=754; blank timing is unchanged versus the undefined build.
